// File: rtl/spike_pkg.sv
// Shared definitions for the time-to-first-spike encoder.
//   DEF_NUM_SPIKES / DEF_TIME_PERIOD : default lane count and gamma length
//   spike_time_t                     : per-lane spike time at the default width
//   NO_SPIKE                         : time value that never fires
//   enc_state_t                      : encoder FSM states
package spike_pkg;

  localparam int DEF_NUM_SPIKES = 8;
  localparam int DEF_TIME_PERIOD = 16;

  localparam int DEF_TBITS = $clog2(DEF_TIME_PERIOD) + 1;

  typedef logic [DEF_TBITS-1:0] spike_time_t;

  // Any value >= TIME_PERIOD is silent; TIME_PERIOD itself is the canonical one.
  localparam spike_time_t NO_SPIKE = spike_time_t'(DEF_TIME_PERIOD);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } enc_state_t;

endpackage

// File: rtl/spike_lane.sv
// One encoder lane: holds the active spike time for the current gamma and
// pulses when the shared step counter reaches it.
//   clk, rst_l : clock, asynchronous active-low reset
//   load_i     : capture time_i as the active time (start of a gamma)
//   time_i     : spike time from the shadow buffer
//   step_i     : current step within the gamma
//   busy_i     : gamma in progress
//   spike_o    : one-step spike pulse
module spike_lane #(
  parameter int TIME_PERIOD = 16,
  parameter int TBITS       = $clog2(TIME_PERIOD) + 1
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             load_i,
  input  logic [TBITS-1:0] time_i,
  input  logic [TBITS-1:0] step_i,
  input  logic             busy_i,
  output logic             spike_o
);

  localparam logic [TBITS-1:0] SILENT_TIME = TBITS'(TIME_PERIOD);

  logic [TBITS-1:0] time_q;
  logic [TBITS-1:0] time_d;

  always_comb begin
    time_d = time_q;
    if (load_i) time_d = time_i;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) time_q <= SILENT_TIME;
    else        time_q <= time_d;
  end

  // step_i never exceeds TIME_PERIOD-1, so out-of-range times can never match.
  assign spike_o = busy_i && (time_q == step_i);

endmodule

// File: rtl/spike_time_encoder.sv
// Time-to-first-spike encoder. Accepts a vector of per-lane spike times over a
// valid/ready handshake into a shadow buffer, then replays it as one gamma of
// TIME_PERIOD steps; lane i pulses once, at the step equal to its time.
// The shadow buffer loads while a gamma runs, so gammas can run back-to-back.
//   clk, rst_l  : clock, asynchronous active-low reset
//   in_valid    : in_times valid
//   in_ready    : shadow buffer empty (registered)
//   in_times    : packed per-lane spike times, lane i at [i*TBITS +: TBITS]
//   spikes_out  : one-step spike pulses
//   step        : current step within the gamma
//   gamma_start : high during step 0 of each gamma
//   gamma_done  : high during the last step of each gamma
//   busy        : gamma in progress
module spike_time_encoder
  import spike_pkg::*;
#(
  parameter int NUM_SPIKES  = DEF_NUM_SPIKES,
  parameter int TIME_PERIOD = DEF_TIME_PERIOD,
  parameter int TBITS       = $clog2(TIME_PERIOD) + 1
) (
  input  logic                        clk,
  input  logic                        rst_l,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_SPIKES*TBITS-1:0] in_times,
  output logic [NUM_SPIKES-1:0]       spikes_out,
  output logic [TBITS-1:0]            step,
  output logic                        gamma_start,
  output logic                        gamma_done,
  output logic                        busy
);

  localparam logic [TBITS-1:0] LAST_STEP = TBITS'(TIME_PERIOD - 1);

  enc_state_t                  state_q, state_d;
  logic [TBITS-1:0]            step_q, step_d;
  logic [NUM_SPIKES*TBITS-1:0] shadow_q, shadow_d;
  logic                        shadow_full_q, shadow_full_d;
  logic                        in_ready_q;
  logic                        load_active;
  logic                        accept;

  // in_ready is a register, so acceptance never depends combinationally on in_valid.
  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    load_active   = 1'b0;
    shadow_full_d = shadow_full_q;
    shadow_d      = shadow_q;

    unique case (state_q)
      IDLE: begin
        if (shadow_full_q) begin
          load_active = 1'b1;
          step_d      = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (step_q == LAST_STEP) begin
          step_d = '0;
          // A waiting vector starts immediately: no gap cycle between gammas.
          if (shadow_full_q) load_active = 1'b1;
          else               state_d     = IDLE;
        end else begin
          step_d = step_q + TBITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // accept needs an empty shadow and load_active a full one, so they never coincide.
    if (load_active) shadow_full_d = 1'b0;
    if (accept) begin
      shadow_full_d = 1'b1;
      shadow_d      = in_times;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q       <= IDLE;
      step_q        <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      in_ready_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      in_ready_q    <= !shadow_full_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign step        = step_q;
  assign in_ready    = in_ready_q;
  assign gamma_start = busy && (step_q == '0);
  assign gamma_done  = busy && (step_q == LAST_STEP);

  generate
    for (genvar gi = 0; gi < NUM_SPIKES; gi++) begin : g_lane
      spike_lane #(
        .TIME_PERIOD (TIME_PERIOD),
        .TBITS       (TBITS)
      ) u_lane (
        .clk     (clk),
        .rst_l   (rst_l),
        .load_i  (load_active),
        .time_i  (shadow_q[gi*TBITS +: TBITS]),
        .step_i  (step_q),
        .busy_i  (busy),
        .spike_o (spikes_out[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_spike_time_encoder.sv
// Scoreboard bench for spike_time_encoder (8 lanes, 16-step gamma).
// The model works at the level of whole transfers: each accepted vector is
// assigned the clock edge its gamma starts on (one edge after the transfer, or
// right after the previous gamma ends, whichever is later), and its 16
// per-step expected outputs are queued against that edge. The shadow buffer
// counts as occupied from the transfer edge until its gamma's start edge.
module tb_spike_time_encoder;

  localparam int NS = 8;
  localparam int TP = 16;
  localparam int TB = 5;

  logic             clk = 1'b0;
  logic             rst_l = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [NS*TB-1:0] in_times = '0;
  logic [NS-1:0]    spikes_out;
  logic [TB-1:0]    step;
  logic             gamma_start, gamma_done, busy;

  spike_time_encoder #(.NUM_SPIKES(NS), .TIME_PERIOD(TP), .TBITS(TB)) dut (
    .clk(clk), .rst_l(rst_l), .in_valid(in_valid), .in_ready(in_ready),
    .in_times(in_times), .spikes_out(spikes_out), .step(step),
    .gamma_start(gamma_start), .gamma_done(gamma_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int edge_no; logic [NS-1:0] spikes; int stp; } rec_t;
  typedef struct { int h; int start; } pend_t;

  rec_t  recq[$];
  pend_t pendq[$];
  int    edge_cnt = 0;
  int    last_end = -10;
  int    compared = 0;
  int    mismatched = 0;
  bit    mon_en = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    compared++;
    if (act !== exp_v) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: timed out got 0 expected 1 (t=%0t)", name, $time);
  endtask

  // Model: called just after the transfer edge h.
  task automatic model_accept(input logic [NS*TB-1:0] v, input int h);
    int start;
    logic [NS-1:0] sp;
    logic [TB-1:0] t;
    rec_t r;
    pend_t p;
    start = (h + 1 > last_end + 1) ? h + 1 : last_end + 1;
    last_end = start + TP - 1;
    p.h = h; p.start = start;
    pendq.push_back(p);
    for (int s = 0; s < TP; s++) begin
      sp = '0;
      for (int i = 0; i < NS; i++) begin
        t = v[i*TB +: TB];
        if (int'(t) == s) sp[i] = 1'b1;
      end
      r.edge_no = start + s; r.spikes = sp; r.stp = s;
      recq.push_back(r);
    end
    $display("xfer edge=%0d times=%010h gamma_start_edge=%0d", h, v, start);
  endtask

  // Monitor: compares every cycle's outputs against the model.
  logic [16:0] act_w, exp_w;
  rec_t        mr;
  always @(negedge clk) begin
    if (mon_en && rst_l) begin
      exp_w = '0;
      if (recq.size() > 0 && recq[0].edge_no == edge_cnt) begin
        mr = recq.pop_front();
        exp_w[16]   = 1'b1;
        exp_w[15:8] = mr.spikes;
        exp_w[7:3]  = TB'(mr.stp);
        exp_w[2]    = (mr.stp == 0);
        exp_w[1]    = (mr.stp == TP - 1);
      end
      while (pendq.size() > 0 && pendq[0].start <= edge_cnt) void'(pendq.pop_front());
      exp_w[0] = (pendq.size() == 0);
      act_w = {busy, spikes_out, step, gamma_start, gamma_done, in_ready};
      compared++;
      if (act_w !== exp_w) begin
        mismatched++;
        $display("FAIL cycle edge=%0d {busy,spikes,step,start,done,ready}: got %05h expected %05h",
                 edge_cnt, act_w, exp_w);
      end
    end
  end

  task automatic send(input logic [NS*TB-1:0] v);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_times = v;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      in_valid = 1'b0;
      fail_timeout("handshake");
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_accept(v, edge_cnt);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((recq.size() > 0 || busy) && n < 500) begin @(negedge clk); n++; end
    if (recq.size() > 0 || busy) fail_timeout("drain");
    @(negedge clk);
  endtask

  task automatic wait_step(input int s);
    int n = 0;
    @(negedge clk);
    while (!(busy && int'(step) == s) && n < 100) begin @(negedge clk); n++; end
    if (!(busy && int'(step) == s)) fail_timeout("wait_step");
  endtask

  // Asserted wherever the caller stands (mid-clock); outputs must clear at once.
  task automatic do_reset();
    rst_l = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_spikes", 32'(spikes_out), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_step", 32'(step), 32'h0);
    check("rst_gstart_gdone", 32'({gamma_start, gamma_done}), 32'h0);
    recq.delete();
    pendq.delete();
    last_end = -10;
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
  endtask

  function automatic logic [NS*TB-1:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    logic [NS*TB-1:0] v;
    v = {TB'(a7), TB'(a6), TB'(a5), TB'(a4), TB'(a3), TB'(a2), TB'(a1), TB'(a0)};
    return v;
  endfunction

  function automatic logic [NS*TB-1:0] rand_vec();
    logic [NS*TB-1:0] v;
    for (int i = 0; i < NS; i++)
      v[i*TB +: TB] = ($urandom_range(0, 3) == 0) ? TB'($urandom_range(16, 31))
                                                   : TB'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    // 1. reset mid-clock
    @(posedge clk);
    #3;
    do_reset();
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    // 2. staircase
    send(pk(0, 1, 2, 3, 4, 5, 6, 7));
    wait_idle();
    // 3. edges of the gamma
    send(pk(16, 16, 15, 0, 16, 16, 16, 16));
    wait_idle();
    // 4. simultaneous and silent
    send(pk(5, 5, 5, 5, 5, 5, 5, 5));
    wait_idle();
    send(pk(16, 16, 16, 16, 16, 16, 16, 16));
    wait_idle();

    // 5. back-to-back A, B during A, C held until B starts
    send(pk(3, 9, 0, 15, 7, 20, 1, 12));
    wait_step(3);
    send(pk(15, 14, 13, 12, 11, 10, 9, 8));
    send(pk(2, 2, 31, 4, 0, 15, 6, 17));
    wait_idle();

    // randomized traffic with gaps and abandoned in_valid pulses
    for (int k = 0; k < 20; k++) begin
      int gap;
      gap = $urandom_range(0, 20);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        if (!in_ready && $urandom_range(0, 3) == 0) begin
          in_valid = 1'b1;
          in_times = rand_vec();
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      send(rand_vec());
    end
    wait_idle();

    // 6. reset at step 7 with the shadow full
    send(pk(7, 3, 16, 0, 9, 15, 2, 7));
    wait_step(2);
    send(pk(1, 1, 1, 1, 1, 1, 1, 1));
    wait_step(7);
    do_reset();
    repeat (40) @(negedge clk);
    send(pk(4, 8, 12, 0, 16, 2, 6, 10));
    wait_idle();

    check("final_queue_empty", 32'(recq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
